// File: rtl/pool2d_stream.sv
// Streaming 2x2 / stride-2 max or average pooling over a raster-ordered
// feature map, with CH lanes processed in parallel and one line buffer.
module pool2d_stream #(
    parameter int DATA_W = 12,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int CH     = 1,
    parameter int SIGNED = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CH*DATA_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CH*DATA_W-1:0] out_data,
    output logic                 out_last,
    output logic                 frame_done
);

    localparam int SW = DATA_W + 2;
    localparam int PW = IMG_W / 2;
    localparam int PH = IMG_H / 2;
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int LW = (PW > 1) ? $clog2(PW) : 1;

    logic [CW-1:0]          col;
    logic [RW-1:0]          row;
    logic                   mode_q;
    logic [CH*DATA_W-1:0]   h_hold;
    logic [CH*SW-1:0]       linebuf [PW];

    logic                   accept;
    logic                   col_end;
    logic                   row_end;
    logic                   in_win;
    logic                   h_done;
    logic                   win_done;
    logic                   win_last;
    logic [LW-1:0]          lb_idx;
    logic [CH*SW-1:0]       lb_rd;
    logic [CH*SW-1:0]       h_vec;
    logic [CH*SW-1:0]       v_vec;
    logic [CH*DATA_W-1:0]   res_vec;

    function automatic logic [SW-1:0] ext(input logic [DATA_W-1:0] p);
        if (SIGNED != 0) return {{2{p[DATA_W-1]}}, p};
        else             return {2'b00, p};
    endfunction

    function automatic logic [SW-1:0] op2(input logic [SW-1:0] a,
                                          input logic [SW-1:0] b,
                                          input logic          avg);
        if (avg)              return a + b;
        else if (SIGNED != 0) return ($signed(a) > $signed(b)) ? a : b;
        else                  return (a > b) ? a : b;
    endfunction

    assign in_ready = !rst && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign col_end  = (col == CW'(IMG_W - 1));
    assign row_end  = (row == RW'(IMG_H - 1));
    assign in_win   = (int'(col) < 2 * PW) && (int'(row) < 2 * PH);
    assign h_done   = accept && in_win && col[0];
    assign win_done = h_done && row[0];
    assign win_last = (int'(row) == 2 * PH - 1) && (int'(col) == 2 * PW - 1);
    assign lb_idx   = LW'(col >> 1);
    assign lb_rd    = linebuf[lb_idx];

    // Average keeps the full DATA_W+2 sum; dropping two LSBs of it is the
    // floor division by 4 for both signed and unsigned data.
    always_comb begin
        h_vec   = '0;
        v_vec   = '0;
        res_vec = '0;
        for (int unsigned k = 0; k < CH; k++) begin
            h_vec[k*SW +: SW] = op2(ext(h_hold[k*DATA_W +: DATA_W]),
                                    ext(in_data[k*DATA_W +: DATA_W]), mode_q);
            v_vec[k*SW +: SW] = op2(lb_rd[k*SW +: SW], h_vec[k*SW +: SW], mode_q);
            res_vec[k*DATA_W +: DATA_W] = mode_q ? v_vec[k*SW+2 +: DATA_W]
                                                 : v_vec[k*SW +: DATA_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col        <= '0;
            row        <= '0;
            mode_q     <= 1'b0;
            h_hold     <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= accept && col_end && row_end;
            if (accept) begin
                col <= col_end ? '0 : col + 1'b1;
                if (col_end) row <= row_end ? '0 : row + 1'b1;
                if (col == '0 && row == '0) mode_q <= mode;
                if (!col[0]) h_hold <= in_data;
            end
            if (win_done) begin
                out_valid <= 1'b1;
                out_data  <= res_vec;
                out_last  <= win_last;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (h_done && !row[0]) linebuf[lb_idx] <= h_vec;
    end

endmodule

// File: tb/tb_pool2d_stream.sv
// Directed bench for pool2d_stream: three configurations checked against a
// frame-level pooling model, plus literal pins taken from hand calculation.
module tb_pool2d_stream;

    typedef int iq_t[$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mode = 1'b0;

    logic a_iv = 1'b0, a_ir, a_ov, a_or = 1'b1, a_ol, a_fd;
    logic [11:0] a_id = '0, a_od;
    logic b_iv = 1'b0, b_ir, b_ov, b_or = 1'b1, b_ol, b_fd;
    logic [23:0] b_id = '0, b_od;
    logic c_iv = 1'b0, c_ir, c_ov, c_or = 1'b1, c_ol, c_fd;
    logic [11:0] c_id = '0, c_od;

    int tests = 0;
    int fails = 0;
    int cnt_a = 0, cnt_b = 0, cnt_c = 0;
    logic fd_a = 1'b0, fd_b = 1'b0, fd_c = 1'b0;

    int ea_d[$], eb_d[$], ec_d[$];
    bit ea_l[$], eb_l[$], ec_l[$];
    int got_a[$], got_b[$], got_c[$];

    always #5 clk = ~clk;

    pool2d_stream #(.DATA_W(12), .IMG_W(4), .IMG_H(4), .CH(1), .SIGNED(0)) u_a (
        .clk(clk), .rst(rst), .mode(mode), .in_valid(a_iv), .in_ready(a_ir),
        .in_data(a_id), .out_valid(a_ov), .out_ready(a_or), .out_data(a_od),
        .out_last(a_ol), .frame_done(a_fd));

    pool2d_stream #(.DATA_W(12), .IMG_W(2), .IMG_H(2), .CH(2), .SIGNED(1)) u_b (
        .clk(clk), .rst(rst), .mode(mode), .in_valid(b_iv), .in_ready(b_ir),
        .in_data(b_id), .out_valid(b_ov), .out_ready(b_or), .out_data(b_od),
        .out_last(b_ol), .frame_done(b_fd));

    pool2d_stream #(.DATA_W(12), .IMG_W(5), .IMG_H(5), .CH(1), .SIGNED(0)) u_c (
        .clk(clk), .rst(rst), .mode(mode), .in_valid(c_iv), .in_ready(c_ir),
        .in_data(c_id), .out_valid(c_ov), .out_ready(c_or), .out_data(c_od),
        .out_last(c_ol), .frame_done(c_fd));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Pooled map computed directly from the whole frame.
    function automatic iq_t pool_model(input int w, input int h, input iq_t px, input bit avg);
        iq_t q;
        int p0, p1, p2, p3, m;
        for (int r = 0; r < h / 2; r++) begin
            for (int c = 0; c < w / 2; c++) begin
                p0 = px[2*r*w + 2*c];
                p1 = px[2*r*w + 2*c + 1];
                p2 = px[(2*r+1)*w + 2*c];
                p3 = px[(2*r+1)*w + 2*c + 1];
                if (avg) m = (p0 + p1 + p2 + p3) >>> 2;
                else begin
                    m = p0;
                    if (p1 > m) m = p1;
                    if (p2 > m) m = p2;
                    if (p3 > m) m = p3;
                end
                q.push_back(m & 'hFFF);
            end
        end
        return q;
    endfunction

    function automatic iq_t ramp(input int n);
        iq_t q;
        for (int i = 0; i < n; i++) q.push_back(i);
        return q;
    endfunction

    task automatic expect_a(input iq_t q);
        foreach (q[i]) begin ea_d.push_back(q[i]); ea_l.push_back(i == q.size() - 1); end
        got_a.delete();
    endtask

    task automatic expect_c(input iq_t q);
        foreach (q[i]) begin ec_d.push_back(q[i]); ec_l.push_back(i == q.size() - 1); end
        got_c.delete();
    endtask

    task automatic push_a(input logic [11:0] v);
        int t = 0;
        a_iv = 1'b1; a_id = v;
        #1;
        while (!a_ir && t < 100) begin @(posedge clk); #3; t++; end
        if (!a_ir) chk("a_accept_timeout", {31'd0, a_ir}, 1);
        @(posedge clk); #2;
        a_iv = 1'b0;
    endtask

    task automatic push_b(input logic [23:0] v);
        int t = 0;
        b_iv = 1'b1; b_id = v;
        #1;
        while (!b_ir && t < 100) begin @(posedge clk); #3; t++; end
        if (!b_ir) chk("b_accept_timeout", {31'd0, b_ir}, 1);
        @(posedge clk); #2;
        b_iv = 1'b0;
    endtask

    task automatic push_c(input logic [11:0] v);
        int t = 0;
        c_iv = 1'b1; c_id = v;
        #1;
        while (!c_ir && t < 100) begin @(posedge clk); #3; t++; end
        if (!c_ir) chk("c_accept_timeout", {31'd0, c_ir}, 1);
        @(posedge clk); #2;
        c_iv = 1'b0;
    endtask

    task automatic drain(input int which);
        int t = 0;
        while (t < 60 && ((which == 0 && (ea_d.size() != 0 || a_ov)) ||
                          (which == 1 && (eb_d.size() != 0 || b_ov)) ||
                          (which == 2 && (ec_d.size() != 0 || c_ov)))) begin
            @(posedge clk); #2; t++;
        end
        if (which == 0) chk("a_drain_left", ea_d.size(), 0);
        if (which == 1) chk("b_drain_left", eb_d.size(), 0);
        if (which == 2) chk("c_drain_left", ec_d.size(), 0);
    endtask

    // Expected frame_done: the cycle after the frame's final pixel is accepted.
    always @(posedge clk) begin
        if (rst) begin
            cnt_a <= 0; cnt_b <= 0; cnt_c <= 0;
            fd_a <= 1'b0; fd_b <= 1'b0; fd_c <= 1'b0;
        end else begin
            fd_a <= a_iv && a_ir && cnt_a == 15;
            fd_b <= b_iv && b_ir && cnt_b == 3;
            fd_c <= c_iv && c_ir && cnt_c == 24;
            if (a_iv && a_ir) cnt_a <= (cnt_a == 15) ? 0 : cnt_a + 1;
            if (b_iv && b_ir) cnt_b <= (cnt_b == 3)  ? 0 : cnt_b + 1;
            if (c_iv && c_ir) cnt_c <= (cnt_c == 24) ? 0 : cnt_c + 1;
        end
    end

    always @(negedge clk) begin
        chk("a_frame_done", {31'd0, a_fd}, {31'd0, fd_a});
        chk("b_frame_done", {31'd0, b_fd}, {31'd0, fd_b});
        chk("c_frame_done", {31'd0, c_fd}, {31'd0, fd_c});
        if (a_ov && a_or) begin
            if (ea_d.size() == 0) chk("a_spurious_out", {31'd0, a_ov & a_or}, 0);
            else begin
                chk("a_data", a_od, ea_d.pop_front());
                chk("a_last", {31'd0, a_ol}, {31'd0, ea_l.pop_front()});
                got_a.push_back(a_od);
            end
        end
        if (b_ov && b_or) begin
            if (eb_d.size() == 0) chk("b_spurious_out", {31'd0, b_ov & b_or}, 0);
            else begin
                chk("b_data", b_od, eb_d.pop_front());
                chk("b_last", {31'd0, b_ol}, {31'd0, eb_l.pop_front()});
                got_b.push_back(b_od);
            end
        end
        if (c_ov && c_or) begin
            if (ec_d.size() == 0) chk("c_spurious_out", {31'd0, c_ov & c_or}, 0);
            else begin
                chk("c_data", c_od, ec_d.pop_front());
                chk("c_last", {31'd0, c_ol}, {31'd0, ec_l.pop_front()});
                got_c.push_back(c_od);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1);
    end

    initial begin
        iq_t l0, l1, q0, q1;

        repeat (3) @(posedge clk);
        #2;
        chk("rst_out_valid", {31'd0, a_ov}, 0);
        chk("rst_out_data", a_od, 0);
        chk("rst_out_last", {31'd0, a_ol}, 0);
        chk("rst_frame_done", {31'd0, a_fd}, 0);
        chk("rst_in_ready_a", {31'd0, a_ir}, 0);
        chk("rst_in_ready_b", {31'd0, b_ir}, 0);
        chk("rst_out_data_b", b_od, 0);
        rst = 1'b0;
        @(posedge clk); #2;

        // Max 4x4
        mode = 1'b0;
        expect_a(pool_model(4, 4, ramp(16), 1'b0));
        for (int i = 0; i < 16; i++) push_a(12'(i));
        drain(0);
        chk("max_pin0", got_a[0], 5);
        chk("max_pin1", got_a[1], 7);
        chk("max_pin2", got_a[2], 13);
        chk("max_pin3", got_a[3], 15);

        // Average 4x4, mode toggled after the first pixel
        mode = 1'b1;
        expect_a(pool_model(4, 4, ramp(16), 1'b1));
        for (int i = 0; i < 16; i++) begin
            push_a(12'(i));
            mode = ~mode;
        end
        drain(0);
        chk("avg_pin0", got_a[0], 2);
        chk("avg_pin1", got_a[1], 4);
        chk("avg_pin2", got_a[2], 10);
        chk("avg_pin3", got_a[3], 12);

        // Backpressure: hold the first result for three cycles
        mode = 1'b0;
        expect_a(pool_model(4, 4, ramp(16), 1'b0));
        fork
            begin
                for (int i = 0; i < 16; i++) push_a(12'(i));
            end
            begin
                int t;
                t = 0;
                while (!a_ov && t < 100) begin @(posedge clk); #2; t++; end
                a_or = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    #1;
                    chk("bp_hold_data", a_od, 5);
                    chk("bp_hold_valid", {31'd0, a_ov}, 1);
                    chk("bp_in_ready", {31'd0, a_ir}, 0);
                    @(posedge clk); #1;
                end
                a_or = 1'b1;
            end
        join
        drain(0);
        chk("bp_count", got_a.size(), 4);
        chk("bp_pin0", got_a[0], 5);
        chk("bp_pin3", got_a[3], 15);

        // Reset mid-frame: result 5 is held unconsumed, then dropped by reset
        a_or = 1'b0;
        for (int i = 0; i < 6; i++) push_a(12'(i));
        #1;
        chk("abort_held_valid", {31'd0, a_ov}, 1);
        rst = 1'b1;
        @(posedge clk); #2;
        chk("abort_valid_cleared", {31'd0, a_ov}, 0);
        chk("abort_in_ready", {31'd0, a_ir}, 0);
        rst = 1'b0;
        a_or = 1'b1;
        expect_a(pool_model(4, 4, ramp(16), 1'b0));
        for (int i = 0; i < 16; i++) push_a(12'(i));
        drain(0);
        chk("abort_count", got_a.size(), 4);
        chk("abort_pin0", got_a[0], 5);
        chk("abort_pin3", got_a[3], 15);

        // Signed, two lanes, 2x2: max then average
        l0.delete(); l1.delete();
        for (int i = 1; i <= 4; i++) begin l0.push_back(-i); l1.push_back(i); end
        for (int m = 0; m < 2; m++) begin
            mode = m[0];
            q0 = pool_model(2, 2, l0, m[0]);
            q1 = pool_model(2, 2, l1, m[0]);
            foreach (q0[i]) begin
                eb_d.push_back((q1[i] << 12) | q0[i]);
                eb_l.push_back(i == q0.size() - 1);
            end
            for (int i = 0; i < 4; i++) push_b({12'(l1[i]), 12'(l0[i])});
            drain(1);
        end
        chk("signed_max_pin", got_b[0], 32'h004FFF);
        chk("signed_avg_pin", got_b[1], 32'h002FFD);

        // Odd 5x5 with idle gaps between some pixels
        mode = 1'b0;
        expect_c(pool_model(5, 5, ramp(25), 1'b0));
        for (int i = 0; i < 25; i++) begin
            push_c(12'(i));
            if (i % 7 == 3) begin @(posedge clk); #2; end
        end
        drain(2);
        chk("odd_pin0", got_c[0], 6);
        chk("odd_pin1", got_c[1], 8);
        chk("odd_pin2", got_c[2], 16);
        chk("odd_pin3", got_c[3], 18);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pool2d_stream.md
# pool2d_stream

Parametrised streaming 2x2/stride-2 pooling engine for the LeNet-5 datapath. It consumes a raster-ordered feature map of IMG_W x IMG_H pixels, with CH channels in parallel lanes, over a valid/ready handshake. It emits the pooled map of floor(IMG_W/2) x floor(IMG_H/2) pixels in raster order, in either max or average mode. It sits between a convolution/activation stage and the next layer's input buffer, and replaces fixed-size, address-driven pooling with a line-buffered stream.

## Interface
- DATA_W, 12, pixel width per channel
- IMG_W, 28, input columns (>=2)
- IMG_H, 28, input rows (>=2)
- CH, 1, channel lanes, packed LSB-first (lane k = data[k*DATA_W +: DATA_W])
- SIGNED, 0, 1 = two's-complement compare/average, 0 = unsigned
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- mode  in  1  0 = max, 1 = average; sampled at frame start
- in_valid  in  1  input pixel valid
- in_ready  out  1  block accepts pixel
- in_data  in  CH*DATA_W  input pixel, all lanes
- out_valid  out  1  pooled pixel valid
- out_ready  in  1  downstream accepts
- out_data  out  CH*DATA_W  pooled pixel
- out_last  out  1  qualifies last pooled pixel of frame
- frame_done  out  1  one-cycle pulse, input frame fully consumed

## Operation
- Accept: in_valid && in_ready at rising edge. in_ready = !rst && (!out_valid || out_ready), so the input stalls only while a held output is blocked.
- Counters col (0..IMG_W-1) and row (0..IMG_H-1) advance per accept. Both wrap to 0 after (IMG_H-1, IMG_W-1).
- mode_q latches mode on accept of (row 0, col 0). mode changes mid-frame have no effect.
- Valid window pixels: col < 2*floor(IMG_W/2) and row < 2*floor(IMG_H/2). Trailing odd column/row pixels are accepted and discarded.
- Horizontal stage, per lane:
  - Even col: h_hold <= pixel.
  - Odd col: h = op(h_hold, pixel).
  - op is max under mode_q=0 and sum under mode_q=1.
  - Sums are kept DATA_W+2 wide, sign-extended if SIGNED.
- Vertical stage, using a line buffer of floor(IMG_W/2) entries x CH lanes x (DATA_W+2) bits:
  - Even row, odd col: linebuf[col>>1] <= h.
  - Odd row, odd col: result = op(linebuf[col>>1], h), loaded into the output register with out_valid=1.
- Average result = 4-pixel sum >>> 2: arithmetic shift, floor toward -inf, truncated to DATA_W. Max result passes through unchanged.
- Compare is signed when SIGNED=1; ties select either operand (equal values).
- out_last = 1 with the window at (row 2*floor(IMG_H/2)-1, col 2*floor(IMG_W/2)-1).
- frame_done pulses in the cycle after the accept of pixel (IMG_H-1, IMG_W-1).
- Output register holds out_data/out_last stable while out_valid && !out_ready. It clears out_valid on handshake unless a new result loads in the same cycle.

## Timing
- Reset values:
  - out_valid=0, out_data=0, out_last=0, frame_done=0, in_ready=0 while rst=1.
  - Counters, h_hold and mode_q are 0.
  - Line buffer contents are don't-care; they are always written before being read.
- Latency: out_valid rises the cycle after the accept of the window-completing pixel.
- Throughput: 1 pixel/cycle with out_ready held high; no bubbles across row or frame wrap.
- Simultaneous output handshake and window completion: the new result loads; out_valid stays 1.
- Reset mid-frame: partial state is dropped and the next accepted pixel is (row 0, col 0). No out_valid or frame_done occurs for the aborted frame.
- in_valid low between pixels is allowed at any point; counters hold.

## Test plan
- Max, 4x4, CH=1, pixels 0..15 raster, out_ready=1: outputs 5,7,13,15. out_last is set with 15, and frame_done pulses once after pixel 15.
- Avg, same stimulus with mode=1 at frame start: outputs 2,4,10,12. Toggling mode mid-frame leaves the outputs unchanged.
- SIGNED=1, DATA_W=12, CH=2, 2x2 frame:
  - Lane0 = -1,-2,-3,-4 gives max 0xFFF and avg 0xFFD (-3).
  - Lane1 = 1,2,3,4 gives max 4 and avg 2.
- Odd dims, IMG_W=IMG_H=5, pixels 0..24: outputs 6,8,16,18, with out_last on 18. frame_done pulses only after pixel 24; column 4 and row 4 are ignored.
- Backpressure, 4x4 max: hold out_ready=0 for 3 cycles after the first out_valid. out_data stays 5 and in_ready stays 0; all 4 outputs arrive in order with no loss.
- Reset mid-frame: after 6 accepted pixels, assert rst for 1 cycle, then send a fresh 0..15 frame. Outputs are exactly 5,7,13,15, and there is no spurious output before them.
